// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   lsu_state_t : access sequencing states
//   lsu_req_t   : one accepted access (direction, address, store data, destination tag)
package lsu_pkg;

  localparam int unsigned LSU_ADDR_W      = 32;
  localparam int unsigned LSU_DATA_W      = 32;
  localparam int unsigned LSU_TAG_W       = 5;
  localparam int unsigned WORD_ALIGN_BITS = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT,
    DONE
  } lsu_state_t;

  typedef struct packed {
    logic                  we;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] wdata;
    logic [LSU_TAG_W-1:0]  tag;
  } lsu_req_t;

endpackage

// File: rtl/lsu_watchdog.sv
// Saturating miss counter for the load/store unit.
//   clk, rstn : clock, synchronous active-low reset
//   clear     : restart the count (new access issued)
//   inc       : one more cycle spent waiting on a miss
//   expire    : this increment is the last one allowed (count reaches all-ones)
module lsu_watchdog #(
  parameter int unsigned TIMEOUT_W = 6
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam logic [TIMEOUT_W-1:0] CntMax  = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] CntLast = CntMax - TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + TIMEOUT_W'(1);
    end
  end

  assign expire = inc && (cnt_q == CntLast);

endmodule

// File: rtl/load_store_unit.sv
// Pipeline-side controller for the data-memory port.
//   clk, rstn                         : clock, synchronous active-low reset
//   req_valid/we/addr/wdata/tag       : one access from the MEM stage, held while stall=1
//   stall                             : pipeline must hold
//   resp_valid/resp_data/resp_tag     : single-cycle completion (data 0 for stores/timeouts)
//   err_misalign                      : pulse, misaligned request dropped
//   err_timeout                       : sticky, miss outlasted the watchdog
//   mem_addr/mem_wdata/mem_we/mem_re  : to memory_interface
//   mem_rdata, mem_miss               : from memory_interface (both one cycle late)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W    = LSU_ADDR_W,
  parameter int unsigned DATA_W    = LSU_DATA_W,
  parameter int unsigned TAG_W     = LSU_TAG_W,
  parameter int unsigned TIMEOUT_W = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              err_misalign,
  output logic              err_timeout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_miss
);

  lsu_state_t        state_q;
  lsu_req_t          req_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              err_misalign_q;
  logic              err_timeout_q;
  logic              req_aligned;
  logic              wd_expire;

  assign req_aligned = (req_addr[WORD_ALIGN_BITS-1:0] == '0);

  lsu_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (state_q == ISSUE),
    .inc    ((state_q == WAIT) && mem_miss),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= IDLE;
      req_q          <= '0;
      resp_data_q    <= '0;
      err_misalign_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      err_misalign_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid && req_aligned) begin
            req_q   <= '{we: req_we, addr: req_addr, wdata: req_wdata, tag: req_tag};
            state_q <= ISSUE;
          end else if (req_valid) begin
            err_misalign_q <= 1'b1;
          end
        end
        ISSUE:  state_q <= SETTLE;
        // mem_miss still reflects the previous access here; wait one more cycle
        SETTLE: state_q <= WAIT;
        WAIT: begin
          if (wd_expire) begin
            err_timeout_q <= 1'b1;
            resp_data_q   <= '0;
            state_q       <= DONE;
          end else if (!mem_miss) begin
            resp_data_q <= req_q.we ? '0 : mem_rdata;
            state_q     <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall  = 1'b0;
    mem_we = 1'b0;
    mem_re = 1'b0;
    unique case (state_q)
      IDLE: stall = req_valid && req_aligned;
      ISSUE: begin
        stall  = 1'b1;
        mem_we = req_q.we;
        mem_re = ~req_q.we;
      end
      SETTLE, WAIT: stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign resp_valid   = (state_q == DONE);
  assign resp_data    = resp_data_q;
  assign resp_tag     = req_q.tag;
  assign err_misalign = err_misalign_q;
  assign err_timeout  = err_timeout_q;
  // Address stays on the port after ISSUE so the BRAM output keeps tracking it
  assign mem_addr     = req_q.addr;
  assign mem_wdata    = req_q.wdata;

endmodule
